// File: rtl/seg7_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_io_pkg
// Description : Shared widths, register map and helpers for the seg7_io block
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_io_pkg;

  localparam int SEG_DIGITS = 8;
  localparam int DATA_W     = 32;
  localparam int DIV_W      = 20;
  localparam int IDX_W      = $clog2(SEG_DIGITS);

  // Register select values on seg_addr
  typedef enum logic [1:0] {
    SEG_ADDR_DATA   = 2'd0,
    SEG_ADDR_ENABLE = 2'd1,
    SEG_ADDR_DP     = 2'd2,
    SEG_ADDR_STATUS = 2'd3
  } seg_addr_e;

  // One-hot active-high anode pattern for a digit index
  function automatic logic [SEG_DIGITS-1:0] digit_onehot(input logic [IDX_W-1:0] idx);
    return SEG_DIGITS'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_io_if.sv
`default_nettype none
// ============================================================================
// Module      : seg7_io_if
// Description : CPU IO register bus between MemOrIO/Controller and seg7_io
// Revision    : 1.0 - initial release
// ============================================================================
interface seg7_io_if;
  import seg7_io_pkg::*;

  logic              seg_cs;
  logic              io_write;
  logic              io_read;
  logic [1:0]        seg_addr;
  logic [DATA_W-1:0] seg_wdata;
  logic [DATA_W-1:0] seg_rdata;

  modport master (
    output seg_cs, io_write, io_read, seg_addr, seg_wdata,
    input  seg_rdata
  );

  modport slave (
    input  seg_cs, io_write, io_read, seg_addr, seg_wdata,
    output seg_rdata
  );

endinterface
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_hex_decode
// Description : Hex nibble + decimal point to active-high {dp,g..a} pattern
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decode (
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  // Standard 0-F glyphs, lower-case b and d so they differ from 8 and 0
  always_comb begin
    seg = 8'h00;
    case (nibble)
      4'h0: seg[6:0] = 7'h3F;
      4'h1: seg[6:0] = 7'h06;
      4'h2: seg[6:0] = 7'h5B;
      4'h3: seg[6:0] = 7'h4F;
      4'h4: seg[6:0] = 7'h66;
      4'h5: seg[6:0] = 7'h6D;
      4'h6: seg[6:0] = 7'h7D;
      4'h7: seg[6:0] = 7'h07;
      4'h8: seg[6:0] = 7'h7F;
      4'h9: seg[6:0] = 7'h6F;
      4'hA: seg[6:0] = 7'h77;
      4'hB: seg[6:0] = 7'h7C;
      4'hC: seg[6:0] = 7'h39;
      4'hD: seg[6:0] = 7'h5E;
      4'hE: seg[6:0] = 7'h79;
      default: seg[6:0] = 7'h71;
    endcase
    seg[7] = dp;
  end

endmodule
`default_nettype wire

// File: rtl/seg7_io.sv
`default_nettype none
// ============================================================================
// Module      : seg7_io
// Description : Memory-mapped 8-digit multiplexed seven-segment display with
//               double-buffered registers committed at frame boundaries
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_io
  import seg7_io_pkg::*;
#(
  parameter int CLK_DIV        = 23000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  seg7_io_if.slave              bus,
  output logic [SEG_DIGITS-1:0] seg_an,
  output logic [7:0]            seg_out
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEG_DIGITS - 1);
  localparam logic [7:0]       PIN_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [DATA_W-1:0]     stage_data, disp_data;
  logic [SEG_DIGITS-1:0] stage_en, stage_dp, disp_en, disp_dp;
  logic                  pending, frame_toggle;
  logic [DIV_W-1:0]      div_cnt;
  logic [IDX_W-1:0]      dig_idx;

  seg_addr_e             addr;
  logic                  wr_en, rd_en, stage_wr, force_commit;
  logic                  digit_tick, frame_commit, any_commit;
  logic                  digit_on;
  logic [7:0]            seg_hi, an_next, out_next;

  assign addr         = seg_addr_e'(bus.seg_addr);
  assign wr_en        = bus.seg_cs & bus.io_write;
  assign rd_en        = bus.seg_cs & bus.io_read;
  assign stage_wr     = wr_en & (addr != SEG_ADDR_STATUS);
  assign force_commit = wr_en & (addr == SEG_ADDR_STATUS) & bus.seg_wdata[0];
  assign digit_tick   = (div_cnt == DIV_LAST);
  // A commit only happens on the 7->0 wrap when something is staged
  assign frame_commit = digit_tick & (dig_idx == IDX_LAST) & pending;
  // A force landing on the frame wrap collapses into this single commit
  assign any_commit   = frame_commit | force_commit;

  // Read mux: stage registers are visible, not the displayed copy; idle reads and reset return 0
  always_comb begin
    bus.seg_rdata = '0;
    if (rd_en && reset_n) begin
      case (addr)
        SEG_ADDR_DATA:   bus.seg_rdata = stage_data;
        SEG_ADDR_ENABLE: bus.seg_rdata = {{(DATA_W-SEG_DIGITS){1'b0}}, stage_en};
        SEG_ADDR_DP:     bus.seg_rdata = {{(DATA_W-SEG_DIGITS){1'b0}}, stage_dp};
        default:         bus.seg_rdata = {{(DATA_W-3){1'b0}}, (dig_idx == '0), frame_toggle, pending};
      endcase
    end
  end

  // Scan timebase: each digit is lit for CLK_DIV cycles
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      dig_idx <= '0;
    end else if (digit_tick) begin
      div_cnt <= '0;
      dig_idx <= dig_idx + IDX_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Stage registers take CPU writes at any time
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_data <= '0;
      stage_en   <= '0;
      stage_dp   <= '0;
    end else if (stage_wr) begin
      case (addr)
        SEG_ADDR_DATA:   stage_data <= bus.seg_wdata;
        SEG_ADDR_ENABLE: stage_en   <= bus.seg_wdata[SEG_DIGITS-1:0];
        default:         stage_dp   <= bus.seg_wdata[SEG_DIGITS-1:0];
      endcase
    end
  end

  // Display copy and pending flag; a fresh stage write outranks the commit clearing pending
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      disp_data    <= '0;
      disp_en      <= '0;
      disp_dp      <= '0;
      pending      <= 1'b0;
      frame_toggle <= 1'b0;
    end else begin
      if (any_commit) begin
        disp_data <= stage_data;
        disp_en   <= stage_en;
        disp_dp   <= stage_dp;
      end
      if (frame_commit) frame_toggle <= ~frame_toggle;
      if (stage_wr)        pending <= 1'b1;
      else if (any_commit) pending <= 1'b0;
    end
  end

  assign digit_on = disp_en[dig_idx];

  seg7_hex_decode u_hex_decode (
    .nibble (disp_data[{dig_idx, 2'b00} +: 4]),
    .dp     (disp_dp[dig_idx]),
    .seg    (seg_hi)
  );

  // Active-high drive for the current digit, blank when the digit is disabled
  always_comb begin
    an_next  = digit_on ? digit_onehot(dig_idx) : 8'h00;
    out_next = digit_on ? seg_hi : 8'h00;
    if (SEG_ACTIVE_LOW) begin
      an_next  = ~an_next;
      out_next = ~out_next;
    end
  end

  // Pin registers: one clock behind dig_idx/disp_*
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seg_an  <= PIN_OFF;
      seg_out <= PIN_OFF;
    end else begin
      seg_an  <= an_next;
      seg_out <= out_next;
    end
  end

endmodule
`default_nettype wire

// File: doc/seg7_io.md
Name: seg7_io

Overview:
- Memory-mapped output responder for the CPU's IO write/read path; drives the board's 8-digit multiplexed seven-segment display.
- Accepts single-cycle register writes and reads from the MemOrIO/Controller IO strobes.
- Writes are double-buffered and committed at a scan-frame boundary, so the display never tears.
- Sits beside the LED and switch IO blocks at the CPU top.

Parameters:
- CLK_DIV, 23000, clock cycles each digit is lit (refresh period = 8*CLK_DIV); legal range 2..2^20-1.
- SEG_ACTIVE_LOW, 1, 1 = cathodes and anodes driven active-low (board default).

Ports:
- clock  in  1  CPU clock (same as data memory/IFetch clock).
- reset_n  in  1  asynchronous, active-low reset.
- seg_cs  in  1  block selected by the address decode in MemOrIO.
- io_write  in  1  IO write strobe from Controller; effective only when seg_cs=1.
- io_read  in  1  IO read strobe from Controller; effective only when seg_cs=1.
- seg_addr  in  2  register select: 0 DATA, 1 ENABLE, 2 DP, 3 STATUS.
- seg_wdata  in  32  write data (from MemOrIO write_data).
- seg_rdata  out  32  read data; combinational from registers; 0 when not (seg_cs&io_read).
- seg_an  out  8  digit anodes; one active at a time.
- seg_out  out  8  cathodes {dp,g,f,e,d,c,b,a}.

Behaviour:
- Registers, all cleared asynchronously on reset_n=0: stage_data[31:0], stage_en[7:0], stage_dp[7:0], disp_data, disp_en, disp_dp, pending, div_cnt, dig_idx.
- Write (seg_cs&io_write at posedge):
  - addr0 -> stage_data <= wdata; addr1 -> stage_en <= wdata[7:0]; addr2 -> stage_dp <= wdata[7:0].
  - Any of those writes sets pending=1.
  - addr3 write: wdata[0]=1 forces immediate commit (disp_* <= stage_*, pending=0) on the next clock; other bits ignored.
- Read: addr0-2 return the stage_* values, zero-extended. addr3 returns {29'b0, dig_idx==0, frame_toggle, pending}.
- Scan:
  - div_cnt counts 0..CLK_DIV-1. At terminal count it wraps to 0 and dig_idx increments modulo 8 (7->0 wrap).
- Frame commit: when dig_idx wraps 7->0 and pending=1, disp_* <= stage_* in the same cycle, pending <= 0, and frame_toggle flips.
- Simultaneous events:
  - A write in the same cycle as the commit goes to stage and leaves pending=1; the old stage value is committed. Write-set has priority over commit-clear.
  - A force-commit in the same cycle as a frame commit is one commit.
- Output drive:
  - Digit i active only if disp_en[i]=1; otherwise all anodes are off and seg_out is blank.
  - Nibble = disp_data[4i+3:4i], hex decoded 0-F; dp = disp_dp[i].
  - Outputs are registered: one clock latency from dig_idx/disp_* to pins.
  - Active-low polarity is applied when SEG_ACTIVE_LOW=1.
- Reset values of outputs:
  - seg_an = 8'hFF and seg_out = 8'hFF (all off, active-low).
  - seg_rdata = 0.
  - Display stays blank until the first commit, because disp_en = 0.
- Reset mid-frame: everything clears immediately; any pending stage write is lost.
- io_read and io_write asserted together: the write is performed, and rdata shows the pre-write value.

Decomposition:
- definitions.v gets `define SEG_ADDR_DATA/ENABLE/DP/STATUS (2'd0..3), `define SEG_DIGITS 8 and `define SEG_IO_BASE (IO address base), reusing `ISA_WIDTH for bus widths.
- One sub-module, seg7_hex_decode: combinational, 4-bit nibble + dp -> 8-bit active-high segment pattern.
- Polarity inversion stays in seg7_io.

Test Plan:
- Reset: reset_n=0 mid-scan -> seg_an=8'hFF, seg_out=8'hFF, rdata=0 at addr3; release -> display stays blank.
- Deferred commit (CLK_DIV=4):
  - Stimulus: write DATA=32'h1234_ABCD, ENABLE=8'hFF.
  - Before wrap: addr3 read = 1 (pending), and seg_an stays FF.
  - After 7->0 wrap: digit0 shows D (seg_out=8'hA1), digit7 shows 1 (8'hF9), and pending=0.
- Force commit: write STATUS=1 -> pending clears the next cycle; disp_data equals stage_data with no frame wait.
- Simultaneous write and commit: write DATA=32'h5 on the exact wrap cycle -> old stage value is displayed, pending stays 1, and 5 is shown after the next wrap.
- Enable/DP masks: ENABLE=8'h01, DP=8'h01, DATA=0 -> only seg_an[0]=0, seg_out=8'h40; all other digit slots show anodes FF.
- Not selected: io_write with seg_cs=0 -> no register changes; io_read with seg_cs=0 -> rdata=0.
